aes_128_iter: RTL
=================

AES_128_ITER -- requirements
Module: aes_128_iter

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, AES rounds applied per clock; legal values 1, 2, 5, 10; any other value SHALL be a elaboration error.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  plaintext/key pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a pair this cycle.
REQ-006 SHALL have port in_data  input  128  plaintext; bits [127:120] = FIPS-197 byte 0, column-major.
REQ-007 SHALL have port in_key  input  128  cipher key; same byte order as in_data.
REQ-008 SHALL have port out_valid  output  1  ciphertext available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-010 SHALL have port out_data  output  128  ciphertext, same byte order.
REQ-011 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement AES-128 encryption per FIPS-197, bit-exact with the existing combinational aes_128 for every input pair.
REQ-013 SHALL use FSM states IDLE, RUN, DONE.
REQ-014 Input handshake SHALL complete on a rising edge with in_valid && in_ready; in_data/in_key are sampled only then.
REQ-015 On input handshake: state reg <= in_data ^ in_key, round-key reg <= in_key, round counter <= 0, FSM -> RUN.
REQ-016 In RUN, each cycle SHALL apply ROUNDS_PER_CYCLE rounds, expanding the key on the fly (Rcon 01,02,04,08,10,20,40,80,1b,36), and add ROUNDS_PER_CYCLE to the 4-bit counter.
REQ-017 Round 10 SHALL omit MixColumns; rounds 1-9 SHALL include it.
REQ-018 When the counter reaches 10, FSM -> DONE and out_valid SHALL rise; latency from input handshake edge to out_valid high = 10/ROUNDS_PER_CYCLE cycles.
REQ-019 In DONE, out_data and out_valid SHALL hold stable until out_ready is high.
REQ-020 Output handshake on out_valid && out_ready: FSM -> IDLE, out_valid low next cycle, unless REQ-022 applies.
REQ-021 in_ready SHALL be 1 in IDLE, 0 in RUN, equal to out_ready in DONE (combinational).
REQ-022 Simultaneous output and input handshake in DONE: SHALL retire the result and start the new block (FSM -> RUN) on the same edge; no bubble cycle.
REQ-023 in_valid in RUN SHALL be ignored; the pair is not lost because in_ready is 0.
REQ-024 out_data SHALL be 0 whenever out_valid is 0.
REQ-025 busy SHALL be (state != IDLE).

Reset
REQ-026 rst_n low SHALL asynchronously force FSM = IDLE, state reg, round-key reg, counter = 0.
REQ-027 During and after reset: out_valid = 0, out_data = 0, busy = 0, in_ready = 1.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the block; no out_valid pulse follows.

Structure
REQ-029 Package aes_pkg SHALL hold the S-box table, Rcon table, state typedef (4x4 bytes), FSM enum, and functions sub_bytes, shift_rows, mix_columns, xtime.
REQ-030 One sub-module aes_round SHALL implement a single combinational round plus key-schedule step, with a last-round flag; it is instantiated ROUNDS_PER_CYCLE times in a generate chain.

Verification
REQ-031 FIPS-197 App. B: in_data 3243f6a8885a308d313198a2e0370734, in_key 2b7e151628aed2a6abf7158809cf4f3c -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid 10 cycles after handshake (ROUNDS_PER_CYCLE=1).
REQ-032 FIPS-197 App. C.1: in_data 00112233445566778899aabbccddeeff, in_key 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a at latency 10, 5, 2, 1 for each legal parameter value.
REQ-033 Backpressure: out_ready held 0 for 20 cycles after out_valid -> out_data stable, in_ready 0, second in_valid not accepted until out_ready = 1.
REQ-034 Back-to-back: in_valid held high with two vectors, out_ready = 1 -> second accepted on the output-handshake edge, both results correct, no idle cycle.
REQ-035 Reset mid-RUN: rst_n pulsed low at cycle 4 of a block -> out_valid never rises for it; out_data = 0, in_ready = 1; next vector encrypts correctly.
REQ-036 Random: 1000 random pairs with random in_valid/out_ready stalls -> every out_data matches the aes_128 model, in order, none dropped or duplicated.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 shared types, tables and byte-level transforms.
// The 128-bit block maps onto state_t as [column][row]. Byte 0 is in bits [127:120].
package aes_pkg;

    // Indexed [column][row]. Each element is one byte.
    typedef logic [0:3][0:3][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x in GF(2^8) using the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Get the Rcon for a zero-based round index.
    // Indices past the last round return 0. The last stages of a multi-round
    // chain see such indices while the block sits in DONE.
    function automatic logic [7:0] rcon_at(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx < 4'd10) r = RCON[idx];
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[c][w] = SBOX[s[c][w]];
        return r;
    endfunction

    // Rotate row w left by w positions.
    function automatic state_t shift_rows(input state_t s);
        state_t r;
        logic [1:0] src;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                src     = 2'(c + w);
                r[c][w] = s[src][w];
            end
        return r;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[c][0];
            a1 = s[c][1];
            a2 = s[c][2];
            a3 = s[c][3];
            r[c][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[c][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[c][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[c][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_128_iter_round.sv
// One combinational AES-128 round together with its key-schedule step.
// The new round key is derived first and added at the end of the same round.
module aes_round
    import aes_pkg::*;
(
    input  state_t       state_in,
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    input  logic         last,
    output state_t       state_out,
    output logic [127:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;
    state_t      sb, sr, mc;

    assign {w0, w1, w2, w3} = key_in;
    assign temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    assign n0   = w0 ^ temp;
    assign n1   = n0 ^ w1;
    assign n2   = n1 ^ w2;
    assign n3   = n2 ^ w3;
    assign key_out = {n0, n1, n2, n3};

    assign sb = sub_bytes(state_in);
    assign sr = shift_rows(sb);
    // The final round has no MixColumns.
    assign mc = last ? sr : mix_columns(sr);
    assign state_out = mc ^ key_out;

endmodule

// File: rtl/aes_128_iter.sv
// Iterative AES-128 encryptor with valid/ready handshakes on both sides.
// Each clock applies ROUNDS_PER_CYCLE rounds.
// A finished block can retire on the same edge that accepts the next pair.
module aes_128_iter
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_param
        $error("aes_128_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    localparam logic [3:0] STEP = 4'(ROUNDS_PER_CYCLE);

    fsm_t         fsm, fsm_next;
    state_t       state_q;
    logic [127:0] key_q;
    logic [3:0]   cnt_q;
    logic         in_hs, out_hs;

    state_t       s_chain [0:ROUNDS_PER_CYCLE];
    logic [127:0] k_chain [0:ROUNDS_PER_CYCLE];

    assign s_chain[0] = state_q;
    assign k_chain[0] = key_q;

    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
        logic [3:0] idx;
        assign idx = cnt_q + 4'(i);
        aes_round u_round (
            .state_in  (s_chain[i]),
            .key_in    (k_chain[i]),
            .rcon      (rcon_at(idx)),
            .last      (idx == 4'd9),
            .state_out (s_chain[i+1]),
            .key_out   (k_chain[i+1])
        );
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        fsm_next  = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (fsm != IDLE);
        case (fsm)
            IDLE: in_ready = 1'b1;
            DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
        in_hs  = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        case (fsm)
            IDLE: if (in_hs) fsm_next = RUN;
            RUN:  if (cnt_q + STEP == 4'd10) fsm_next = DONE;
            DONE: begin
                if (in_hs)       fsm_next = RUN;
                else if (out_hs) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
        out_data = out_valid ? state_q : 128'h0;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_next;
    end

    // Block state, round key and round counter.
    // A new pair loads with the initial AddRoundKey already applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else if (in_hs) begin
            state_q <= in_data ^ in_key;
            key_q   <= in_key;
            cnt_q   <= 4'd0;
        end else if (fsm == RUN) begin
            state_q <= s_chain[ROUNDS_PER_CYCLE];
            key_q   <= k_chain[ROUNDS_PER_CYCLE];
            cnt_q   <= cnt_q + STEP;
        end
    end

endmodule
